// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, drives instruction memory and buffers {pc, instr} in a 2-entry FIFO for decode.
// Optional build macro FETCH_PERF_EN enables the delivered-instruction counter on fetch_count.
module instr_fetch #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic              fetch_fault,
   output logic [ADDR_W-1:0] fault_pc,
   output logic [31:0]       fetch_count
);

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned DEPTH   = 2;
   localparam int unsigned CNT_W   = 2;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   logic [ADDR_W-1:0] pc;
   fetch_entry_t      fifo_q [DEPTH];
   logic              rd_ptr;
   logic              wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              fault;
   logic [ADDR_W-1:0] fault_pc_q;
   logic              head_valid;
   logic              pop;
   logic              push;
   logic              misaligned;

   assign head_valid = (count != CNT_W'(0));
   assign if_valid   = head_valid & ~redirect_valid;
   assign pop        = if_valid & if_ready;
   assign push       = ~redirect_valid & ~fault & ((count < CNT_W'(DEPTH)) | pop);
   assign misaligned = (redirect_pc[1:0] != 2'b00);

   assign imem_addr   = pc;
   assign if_pc       = head_valid ? fifo_q[rd_ptr].pc    : '0;
   assign if_instr    = head_valid ? fifo_q[rd_ptr].instr : '0;
   assign fetch_fault = fault;
   assign fault_pc    = fault_pc_q;

   // PC, FIFO and fault state; a redirect flushes the buffer and overrides any push/pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc         <= RESET_PC;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         count      <= '0;
         fault      <= 1'b0;
         fault_pc_q <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else if (redirect_valid) begin
         pc     <= redirect_pc;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
         fault  <= misaligned;
         if (misaligned) fault_pc_q <= redirect_pc;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= '{pc: pc, instr: imem_data};
            wr_ptr         <= ~wr_ptr;
            pc             <= pc + ADDR_W'(4);
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_cnt;

   // Counts every instruction handed to decode; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     perf_cnt <= '0;
      else if (pop) perf_cnt <= perf_cnt + 32'd1;
   end

   assign fetch_count = perf_cnt;
`else
   assign fetch_count = '0;
`endif

endmodule
